// File: rtl/min_pkg.sv
// MIN protocol framing constants, FSM states and CRC helpers
// shared by the transmitter and the planned receiver.
package min_pkg;

  localparam logic [7:0]  MIN_SOF          = 8'hAA;
  localparam logic [7:0]  MIN_EOF          = 8'h55;
  localparam logic [7:0]  MIN_STUFF        = 8'h55;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;
  localparam int          ID_TRANSPORT_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_SEQ,
    ST_LEN,
    ST_PAY,
    ST_CRC,
    ST_EOF
  } min_state_e;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/min_crc32_byte.sv
// One byte step of the reflected CRC-32 (LSB-first shift register).
// Purely combinational so tx and rx can share it.
module min_crc32_byte
  import min_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data_in};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/min_frame_tx.sv
// MIN frame transmitter: SOF, header, payload, CRC-32, EOF with
// byte stuffing, streamed over a registered valid/ready byte port.
module min_frame_tx
  import min_pkg::*;
#(
  parameter int MAX_PAYLOAD  = 32,
  parameter int LEN_W        = $clog2(MAX_PAYLOAD + 1),
  parameter bit TRANSPORT_EN = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_ready,
  input  logic [5:0]               i_id,
  input  logic                     i_transport,
  input  logic [7:0]               i_seq,
  input  logic [LEN_W-1:0]         i_len,
  input  logic [8*MAX_PAYLOAD-1:0] i_data,
  output logic                     o_valid,
  output logic [7:0]               o_data,
  input  logic                     i_ready,
  output logic                     o_done,
  output logic                     o_err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  min_state_e state_q, state_d;

  logic [1:0]  sof_q, sof_d;
  logic [1:0]  crc_cnt_q, crc_cnt_d;
  logic [1:0]  run_q, run_d, run_nx;
  logic        stuff_q, stuff_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, pay_sel;
  logic [31:0] crc_q, crc_d, crc_step, crc_nx, crc_fin;
  logic [7:0]  data_d, id_byte, pay_byte, crc_sel;
  logic        valid_d, done_d, err_d;

  logic [5:0]  id_q;
  logic        tr_q, tr_in;
  logic [7:0]  seq_q;
  logic [8*MAX_PAYLOAD-1:0] data_q;

  logic xfer, len_ok, accept, covered, region;

  assign tr_in   = TRANSPORT_EN ? i_transport : 1'b0;
  assign o_ready = (state_q == ST_IDLE);
  assign len_ok  = (i_len <= MAX_LEN);
  assign accept  = i_start && o_ready && len_ok;
  assign xfer    = o_valid && i_ready;

  // Stuff bytes never feed the CRC; only header and payload do.
  assign covered = !stuff_q &&
    (state_q inside {ST_ID, ST_SEQ, ST_LEN, ST_PAY});
  assign region  =
    (state_q inside {ST_ID, ST_SEQ, ST_LEN, ST_PAY, ST_CRC});
  assign run_nx  = (stuff_q || o_data != MIN_SOF) ? 2'd0
                                                  : run_q + 2'd1;

  min_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data_in (o_data),
    .crc_out (crc_step)
  );

  assign crc_nx  = covered ? crc_step : crc_q;
  assign crc_fin = ~crc_nx;
  assign pay_sel = (state_q == ST_PAY) ? idx_q + 1'b1 : '0;

  always_comb begin
    id_byte = 8'(id_q);
    id_byte[ID_TRANSPORT_BIT] = tr_q;
  end

  always_comb begin
    pay_byte = 8'h00;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (pay_sel == LEN_W'(k)) begin
        pay_byte = data_q[8*(MAX_PAYLOAD-k)-1 -: 8];
      end
    end
  end

  always_comb begin
    unique case (crc_cnt_q)
      2'd0:    crc_sel = crc_fin[23:16];
      2'd1:    crc_sel = crc_fin[15:8];
      default: crc_sel = crc_fin[7:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sof_d     = sof_q;
    idx_d     = idx_q;
    crc_cnt_d = crc_cnt_q;
    run_d     = run_q;
    stuff_d   = stuff_q;
    crc_d     = crc_q;
    data_d    = o_data;
    valid_d   = o_valid;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (state_q == ST_IDLE) begin
      if (i_start && !len_ok) err_d = 1'b1;
      if (accept) begin
        state_d   = ST_SOF;
        sof_d     = 2'd0;
        idx_d     = '0;
        crc_cnt_d = 2'd0;
        run_d     = 2'd0;
        stuff_d   = 1'b0;
        crc_d     = CRC32_INIT;
        data_d    = MIN_SOF;
        valid_d   = 1'b1;
      end
    end else if (xfer) begin
      crc_d = crc_nx;
      if (region) run_d = run_nx;
      // State stays put across a stuff byte, so the
      // advance below resumes from the pre-stuff field.
      if (region && run_nx == 2'd2) begin
        stuff_d = 1'b1;
        data_d  = MIN_STUFF;
      end else begin
        stuff_d = 1'b0;
        case (state_q)
          ST_SOF: begin
            if (sof_q == 2'd2) begin
              state_d = ST_ID;
              data_d  = id_byte;
            end else begin
              sof_d  = sof_q + 2'd1;
              data_d = MIN_SOF;
            end
          end
          ST_ID: begin
            if (tr_q) begin
              state_d = ST_SEQ;
              data_d  = seq_q;
            end else begin
              state_d = ST_LEN;
              data_d  = 8'(len_q);
            end
          end
          ST_SEQ: begin
            state_d = ST_LEN;
            data_d  = 8'(len_q);
          end
          ST_LEN: begin
            if (len_q == '0) begin
              state_d   = ST_CRC;
              crc_cnt_d = 2'd0;
              data_d    = crc_fin[31:24];
            end else begin
              state_d = ST_PAY;
              idx_d   = '0;
              data_d  = pay_byte;
            end
          end
          ST_PAY: begin
            if (idx_q == len_q - 1'b1) begin
              state_d   = ST_CRC;
              crc_cnt_d = 2'd0;
              data_d    = crc_fin[31:24];
            end else begin
              idx_d  = idx_q + 1'b1;
              data_d = pay_byte;
            end
          end
          ST_CRC: begin
            if (crc_cnt_q == 2'd3) begin
              state_d = ST_EOF;
              data_d  = MIN_EOF;
            end else begin
              crc_cnt_d = crc_cnt_q + 2'd1;
              data_d    = crc_sel;
            end
          end
          ST_EOF: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            data_d  = 8'h00;
            done_d  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      sof_q     <= 2'd0;
      idx_q     <= '0;
      crc_cnt_q <= 2'd0;
      run_q     <= 2'd0;
      stuff_q   <= 1'b0;
      crc_q     <= CRC32_INIT;
      o_data    <= 8'h00;
      o_valid   <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      id_q      <= 6'h00;
      tr_q      <= 1'b0;
      seq_q     <= 8'h00;
      len_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      sof_q     <= sof_d;
      idx_q     <= idx_d;
      crc_cnt_q <= crc_cnt_d;
      run_q     <= run_d;
      stuff_q   <= stuff_d;
      crc_q     <= crc_d;
      o_data    <= data_d;
      o_valid   <= valid_d;
      o_done    <= done_d;
      o_err     <= err_d;
      if (accept) begin
        id_q   <= i_id;
        tr_q   <= tr_in;
        seq_q  <= i_seq;
        len_q  <= i_len;
        data_q <= i_data;
      end
    end
  end

endmodule

// File: doc/min_frame_tx.md
# min_frame_tx

Parametrised MIN-protocol frame transmitter. It latches an ID and a variable-length payload (up to MAX_PAYLOAD bytes), optionally adds a transport-mode sequence byte, and computes CRC-32 on the fly. Stuffed bytes are streamed over a valid/ready byte interface to the UART transmitter. It replaces the fixed-length transmit FSM in the sensor readout path and adds variable length, correct byte stuffing, and downstream back-pressure.

## Interface
- MAX_PAYLOAD, 32: maximum payload bytes (1..255).
- LEN_W, $clog2(MAX_PAYLOAD+1): width of i_len.
- TRANSPORT_EN, 0: 1 enables the i_transport input; 0 ties transport mode off.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  frame request; accepted only when o_ready=1.
- o_ready  out  1  idle and able to accept i_start.
- i_id  in  6  MIN identifier.
- i_transport  in  1  transport frame: sets ID bit7 and emits i_seq.
- i_seq  in  8  sequence number (transport only).
- i_len  in  LEN_W  payload length, 0..MAX_PAYLOAD.
- i_data  in  8*MAX_PAYLOAD  payload; byte k at [8*(MAX_PAYLOAD-k)-1 -: 8].
- o_valid  out  1  o_data holds a byte.
- o_data  out  8  frame byte.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_done  out  1  one-cycle pulse on the EOF transfer.
- o_err  out  1  one-cycle pulse when i_start is rejected (i_len>MAX_PAYLOAD).

## Operation
- Transfer: a byte moves when o_valid&&i_ready. o_data/o_valid are registered and held stable until the transfer.
- Accept: i_start&&o_ready with i_len≤MAX_PAYLOAD latches id, transport, seq, len, and data. CRC is initialised to 0xFFFFFFFF. Otherwise o_err pulses and the block stays in IDLE.
- States: IDLE → SOF (3× 0xAA, counter) → ID → [SEQ if transport] → LEN → PAYLOAD (len bytes; skipped if len=0) → CRC (4 bytes) → EOF (0x55) → IDLE.
- ID byte = {transport,1'b0,i_id}.
- CRC-32: reflected, poly 0x04C11DB7, init all-ones, final inversion. It covers ID, SEQ, LEN and payload (pre-stuffing values). The CRC register updates on transfer of each covered byte. It is sent as ~crc, MSB byte first.
- Stuffing applies from ID through the last CRC byte, not to SOF or EOF:
  - A 2-bit AA-run counter increments on each transferred 0xAA and clears on any other byte.
  - When the counter reaches 2, the next byte emitted is 0x55 (stuff). The stuff byte clears the counter and the FSM then resumes with the byte it would have sent next.
  - Stuff bytes are not CRC'd.
- i_start while busy is ignored. o_ready=0 from accept until the cycle after the EOF transfer.

## Timing
- Reset values: o_ready=1, o_valid=0, o_data=0x00, o_done=0, o_err=0, state IDLE, CRC 0xFFFFFFFF, AA-run counter 0.
- Accept on edge N: o_valid=1 with o_data=0xAA from N+1.
- With i_ready held high, one byte per cycle and no bubbles.
- Total bytes = 10 + len + transport + stuff count.
- EOF transfer on edge M: o_done=1 during M+1, o_valid=0 and o_ready=1 from M+1. A new i_start is accepted at M+1 at the earliest.
- i_ready low: state, CRC and counters are frozen and o_data is held.
- i_rst mid-frame: next cycle all outputs take reset values and the frame is truncated (receiver resyncs on SOF). i_rst has priority over i_start.
- The CRC update is combinational from the current byte and CRC register. The next CRC is registered on the transfer edge, so the first CRC byte reflects all covered bytes.

## Structure
- Package min_pkg: MIN_SOF=8'hAA, MIN_EOF=8'h55, MIN_STUFF=8'h55, CRC32_POLY, CRC32_INIT, the state enum, and the transport ID bit position.
- Sub-module min_crc32_byte: combinational 8-bit reflected CRC-32 step (crc_in, byte → crc_out). It is reused by the planned receiver.
- Payload byte select is a mux indexed by a LEN_W byte counter.

## Test plan
- id=0x00, len=0, non-transport, i_ready=1 → exactly AA AA AA 00 00 41 D9 12 FF 55 on consecutive cycles; o_done on the cycle after 0x55.
- id=0x01, len=4, payload AA AA AA AA → payload section emitted as AA AA 55 AA AA 55. LEN byte is 04. CRC equals a software CRC-32 of 01 04 AA AA AA AA, with no stuff bytes in the CRC.
- TRANSPORT_EN=1, transport=1, id=0x05, seq=0x7E, len=1, data 0x10 → ID byte 0x85, then 7E, 01, 10, 4 CRC bytes matching the model, then 55.
- Random i_ready (50%), len=MAX_PAYLOAD with random data → byte stream identical to the i_ready=1 run, and o_data never changes while o_valid&&!i_ready.
- i_len=MAX_PAYLOAD+1 → o_err pulse, no o_valid, o_ready stays 1. i_start during a frame → ignored.
- i_rst asserted in PAYLOAD → o_valid=0 next cycle. A following len=0 frame reproduces case 1 exactly (CRC and AA-run counter cleared).
